// File: rtl/gate_delay_arbiter_pkg.sv
// Shared types for the gate-delay arbiter: gate op codes, controller states
// and the operand bundle latched at grant time.
package gate_delay_arbiter_pkg;

  // 2-bit gate op code as presented on REQ_OP.
  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_XNOR = 2'b11
  } gate_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Operand bundle captured from the winning requester.
  typedef struct packed {
    logic     a;
    logic     b;
    gate_op_e op;
  } operand_t;

endpackage : gate_delay_arbiter_pkg

// File: rtl/gate_delay_arbiter_gate_op_unit.sv
// Combinational 2-input gate evaluation unit shared by all requesters.
//   a, b  : operands
//   op    : gate select (AND/OR/XOR/XNOR)
//   y_c   : combinational gate result
module gate_op_unit
  import gate_delay_arbiter_pkg::*;
(
  input  logic     a,
  input  logic     b,
  input  gate_op_e op,
  output logic     y_c
);

  always_comb begin
    y_c = 1'b0;
    case (op)
      OP_AND:  y_c = a & b;
      OP_OR:   y_c = a | b;
      OP_XOR:  y_c = a ^ b;
      OP_XNOR: y_c = ~(a ^ b);
      default: y_c = 1'b0;
    endcase
  end

endmodule : gate_op_unit

// File: rtl/gate_delay_arbiter.sv
// Round-robin scheduler sharing one gate evaluation unit among N_REQ
// requesters. Latches the winner's operands, holds them SETTLE_CYC cycles,
// then samples the gate result and pulses DONE for the winner.
//   CLK, RST_N : clock, asynchronous active-low reset
//   REQ        : per-requester level request (sampled in IDLE only)
//   REQ_A/B    : per-requester operands, bit i belongs to requester i
//   REQ_OP     : per-requester op code, bits [2i+1:2i]
//   GNT        : one-hot 1-cycle pulse when a request is accepted
//   DONE       : one-hot 1-cycle pulse when X is valid for that requester
//   X          : registered gate result, held until the next DONE
//   BUSY       : high while settling or responding
module gate_delay_arbiter
  import gate_delay_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned SETTLE_CYC = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [N_REQ-1:0]   REQ_A,
  input  logic [N_REQ-1:0]   REQ_B,
  input  logic [2*N_REQ-1:0] REQ_OP,
  output logic [N_REQ-1:0]   GNT,
  output logic [N_REQ-1:0]   DONE,
  output logic               X,
  output logic               BUSY
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt;
  operand_t           opnd;

  logic [PTR_W-1:0]   win_c;
  logic               found_c;
  logic               y_c;
  int unsigned        idx;

  // Round-robin search: first set REQ bit starting just after rr_ptr.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx     = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % N_REQ;
      if (!found_c && REQ[PTR_W'(idx)]) begin
        found_c = 1'b1;
        win_c   = PTR_W'(idx);
      end
    end
  end

  // Shared gate unit driven only by the operands latched at grant.
  gate_op_unit u_gate (
    .a   (opnd.a),
    .b   (opnd.b),
    .op  (opnd.op),
    .y_c (y_c)
  );

  // Controller FSM with registered outputs; reset aborts any operation.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      rr_ptr <= PTR_W'(N_REQ - 1);
      cnt    <= '0;
      opnd   <= '0;
      GNT    <= '0;
      DONE   <= '0;
      X      <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      GNT  <= '0;
      DONE <= '0;
      case (state)
        ST_IDLE: begin
          if (found_c) begin
            opnd.a  <= REQ_A[win_c];
            opnd.b  <= REQ_B[win_c];
            opnd.op <= gate_op_e'(REQ_OP[{win_c, 1'b0} +: 2]);
            rr_ptr  <= win_c;
            cnt     <= CNT_W'(SETTLE_CYC - 1);
            GNT     <= N_REQ'(1) << win_c;
            BUSY    <= 1'b1;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            X     <= y_c;
            DONE  <= N_REQ'(1) << rr_ptr;
            state <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : gate_delay_arbiter
